rv32i_commit_trace: RTL
=======================

RV32I_COMMIT_TRACE -- requirements
Module: rv32i_commit_trace

Interface
- REQ-001 SHALL have parameter FIFO_DEPTH, default 16: trace FIFO entries; power of two, minimum 2.
- REQ-002 SHALL have port i_clk, input, 1: single clock; all logic on rising edge.
- REQ-003 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
- REQ-004 SHALL have port i_ce_wb, input, 1: writeback stage retires one instruction this cycle.
- REQ-005 SHALL have port i_pc, input, 32: PC of the retiring instruction.
- REQ-006 SHALL have port i_inst, input, 32: instruction word of the retiring instruction.
- REQ-007 SHALL have port i_wr_rd, input, 1: base register is written.
- REQ-008 SHALL have port i_rd_addr, input, 5: destination register index.
- REQ-009 SHALL have port i_rd, input, 32: destination register value.
- REQ-010 SHALL have port i_mem_wr, input, 1: data memory is written.
- REQ-011 SHALL have port i_mem_addr, input, 32: store address.
- REQ-012 SHALL have port i_mem_data, input, 32: store data.
- REQ-013 SHALL have port i_ecall, input, 1: retiring instruction is ECALL.
- REQ-014 SHALL have port i_ebreak, input, 1: retiring instruction is EBREAK.
- REQ-015 SHALL have port i_clear, input, 1: synchronous flush.
- REQ-016 SHALL have port i_ready, input, 1: consumer accepts o_entry.
- REQ-017 SHALL have port o_valid, output, 1: o_entry holds a valid trace record.
- REQ-018 SHALL have port o_entry, output, 167: packed record {pc, inst, wr_rd, rd_addr, rd, mem_wr, mem_addr, mem_data}, MSB first.
- REQ-019 SHALL have port o_level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- REQ-020 SHALL have port o_overflow, output, 1: sticky flag; a record was dropped.
- REQ-021 SHALL have port o_retired, output, 32: count of retirements seen while in RUN.
- REQ-022 SHALL have port o_halted, output, 1: core halted and trace fully drained.

Function
- REQ-023 SHALL push exactly one record per cycle in which i_ce_wb=1 and the state is RUN.
- REQ-024 SHALL implement the FIFO as first-word-fall-through: a push into an empty FIFO at cycle N gives o_valid=1 and that record on o_entry at cycle N+1.
- REQ-025 SHALL pop when o_valid && i_ready; o_entry SHALL hold stable while o_valid=1 && i_ready=0.
- REQ-026 SHALL, when the FIFO is full and a push occurs without a pop, drop the new record, leave the contents intact and set o_overflow.
- REQ-027 SHALL, on a simultaneous push and pop while full, accept both; o_level stays at FIFO_DEPTH and o_overflow does not change.
- REQ-028 SHALL increment o_retired on every i_ce_wb=1 in RUN, including dropped records; the counter wraps from 0xFFFFFFFF to 0.
- REQ-029 SHALL wrap the read and write pointers modulo FIFO_DEPTH, with one extra bit used to tell full from empty.
- REQ-030 SHALL, on i_clear=1, empty the FIFO, clear o_overflow, o_retired and o_halted, and enter RUN next cycle; i_clear takes priority over a push or pop in the same cycle.

Reset
- REQ-031 SHALL, on i_rst_n low (asynchronously, including mid-transfer), drive o_valid=0, o_level=0, o_overflow=0, o_retired=0, o_halted=0 and state RUN; o_entry=0.
- REQ-032 SHALL leave FIFO storage contents unreset; records are invalidated through the pointers only.

Configuration
- REQ-033 SHALL, with RV32I_TRACE_HALT_EN defined, run FSM RUN -> HALTING -> HALTED.
  - RUN -> HALTING: on i_ce_wb && (i_ecall || i_ebreak); that record is pushed.
  - HALTING: ignores i_ce_wb. HALTING -> HALTED: when the FIFO is empty.
  - HALTED asserts o_halted; exit only via i_clear or reset.
- REQ-034 SHALL, without RV32I_TRACE_HALT_EN, ignore i_ecall and i_ebreak, stay permanently in RUN and tie o_halted to 0.

Structure
- REQ-035 SHALL take TRACE_W (167), the record field offsets and widths, and the state encoding (RUN=0, HALTING=1, HALTED=2) from package rv32i_trace_pkg.
- REQ-036 SHALL put the storage and pointers in one sub-module, rv32i_trace_fifo; the FSM, counter and flags stay in the top module.

Verification
- REQ-037 Single retire, pc=0x100, inst=0x00500093, rd=x1=5, i_ready=1 -> o_valid=1 one cycle later with those fields; o_level returns to 0.
- REQ-038 i_ready=0 with 17 retires at FIFO_DEPTH=16 -> o_level=16, o_overflow=1, o_retired=17; the drained order is the first 16 records.
- REQ-039 Full FIFO with push and pop in the same cycle -> o_level=16, o_overflow stays 0.
- REQ-040 With RV32I_TRACE_HALT_EN: 3 retires, then ECALL, then 2 retires, i_ready=1 -> 4 records drained, o_halted=1, o_retired=4; without the macro -> 6 records, o_halted=0.
- REQ-041 Assert i_rst_n low with 5 records queued -> all outputs zero immediately; after release, the first new retire appears as the only record.

Source files
------------

// File: rtl/rv32i_trace_pkg.sv
// Shared types for the RV32I commit trace: record layout, field offsets and halt FSM encoding.
package rv32i_trace_pkg;

    localparam int TRACE_W      = 167;
    localparam int MEM_DATA_LSB = 0;
    localparam int MEM_DATA_W   = 32;
    localparam int MEM_ADDR_LSB = 32;
    localparam int MEM_ADDR_W   = 32;
    localparam int MEM_WR_LSB   = 64;
    localparam int RD_LSB       = 65;
    localparam int RD_W         = 32;
    localparam int RD_ADDR_LSB  = 97;
    localparam int RD_ADDR_W    = 5;
    localparam int WR_RD_LSB    = 102;
    localparam int INST_LSB     = 103;
    localparam int INST_W       = 32;
    localparam int PC_LSB       = 135;
    localparam int PC_W         = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTING = 2'd1,
        ST_HALTED  = 2'd2
    } trace_state_e;

    function automatic logic [TRACE_W-1:0] pack_record(
        input logic [PC_W-1:0]       pc,
        input logic [INST_W-1:0]     inst,
        input logic                  wr_rd,
        input logic [RD_ADDR_W-1:0]  rd_addr,
        input logic [RD_W-1:0]       rd,
        input logic                  mem_wr,
        input logic [MEM_ADDR_W-1:0] mem_addr,
        input logic [MEM_DATA_W-1:0] mem_data
    );
        logic [TRACE_W-1:0] r;
        r                             = {TRACE_W{1'b0}};
        r[PC_LSB +: PC_W]             = pc;
        r[INST_LSB +: INST_W]         = inst;
        r[WR_RD_LSB]                  = wr_rd;
        r[RD_ADDR_LSB +: RD_ADDR_W]   = rd_addr;
        r[RD_LSB +: RD_W]             = rd;
        r[MEM_WR_LSB]                 = mem_wr;
        r[MEM_ADDR_LSB +: MEM_ADDR_W] = mem_addr;
        r[MEM_DATA_LSB +: MEM_DATA_W] = mem_data;
        return r;
    endfunction

endpackage

// File: rtl/rv32i_trace_fifo.sv
// First-word-fall-through trace FIFO; pointers carry one extra wrap bit to separate full from empty.
module rv32i_trace_fifo
    import rv32i_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     ready,
    input  logic [TRACE_W-1:0]       din,
    output logic                     valid,
    output logic [TRACE_W-1:0]       dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] INC = {{AW{1'b0}}, 1'b1};

    logic [TRACE_W-1:0] mem_r [DEPTH];
    logic [AW:0]        wr_ptr_r;
    logic [AW:0]        rd_ptr_r;
    logic [AW:0]        level_r;
    logic [AW:0]        level_nx_s;
    logic               valid_r;
    logic               full_s;
    logic               pop_s;
    logic               wr_en_s;

    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s   = valid_r && ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en_s = push && (!full_s || pop_s);
    assign drop    = push && full_s && !pop_s && !clear;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        level_nx_s = level_r;
        case ({wr_en_s, pop_s})
            2'b10:   level_nx_s = level_r + INC;
            2'b01:   level_nx_s = level_r - INC;
            default: level_nx_s = level_r;
        endcase
    end

    // Record storage, deliberately without reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !clear) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointers, occupancy and valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            level_r  <= {(AW+1){1'b0}};
            valid_r  <= 1'b0;
        end else if (clear) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            level_r  <= {(AW+1){1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + INC;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + INC;
            end
            level_r <= level_nx_s;
            valid_r <= (level_nx_s != {(AW+1){1'b0}});
        end
    end

    assign valid = valid_r;
    assign level = level_r;
    assign dout  = valid_r ? mem_r[rd_ptr_r[AW-1:0]] : {TRACE_W{1'b0}};

endmodule

// File: rtl/rv32i_commit_trace.sv
// RV32I commit trace: packs retiring instructions into a trace FIFO with retire count and overflow flag.
// Define RV32I_TRACE_HALT_EN to stop tracing after ECALL/EBREAK and raise o_halted once drained.
module rv32i_commit_trace
    import rv32i_trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ce_wb,
    input  logic [31:0]                   i_pc,
    input  logic [31:0]                   i_inst,
    input  logic                          i_wr_rd,
    input  logic [4:0]                    i_rd_addr,
    input  logic [31:0]                   i_rd,
    input  logic                          i_mem_wr,
    input  logic [31:0]                   i_mem_addr,
    input  logic [31:0]                   i_mem_data,
    input  logic                          i_ecall,
    input  logic                          i_ebreak,
    input  logic                          i_clear,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [TRACE_W-1:0]            o_entry,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic [31:0]                   o_retired,
    output logic                          o_halted
);

    logic                          push_s;
    logic                          drop_s;
    logic [TRACE_W-1:0]            rec_s;
    logic [$clog2(FIFO_DEPTH):0]   level_s;
    logic [31:0]                   retired_r;
    logic                          overflow_r;

    assign rec_s = pack_record(i_pc, i_inst, i_wr_rd, i_rd_addr, i_rd,
                               i_mem_wr, i_mem_addr, i_mem_data);

`ifdef RV32I_TRACE_HALT_EN
    trace_state_e state_r;
    logic         halted_r;

    assign push_s = i_ce_wb && (state_r == ST_RUN);

    // Halt sequencing: stop accepting after ECALL/EBREAK, declare halted once drained.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else if (i_clear) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (i_ce_wb && (i_ecall || i_ebreak)) begin
                        state_r <= ST_HALTING;
                    end
                end
                ST_HALTING: begin
                    if (level_s == {($clog2(FIFO_DEPTH)+1){1'b0}}) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_halted = halted_r;
`else
    logic unused_s;

    assign push_s   = i_ce_wb;
    assign unused_s = i_ecall ^ i_ebreak;
    assign o_halted = 1'b0;
`endif

    // Retire counter and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retired_r  <= 32'd0;
            overflow_r <= 1'b0;
        end else if (i_clear) begin
            retired_r  <= 32'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                retired_r <= retired_r + 32'd1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    rv32i_trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (i_clear),
        .push  (push_s),
        .ready (i_ready),
        .din   (rec_s),
        .valid (o_valid),
        .dout  (o_entry),
        .level (level_s),
        .drop  (drop_s)
    );

    assign o_level    = level_s;
    assign o_overflow = overflow_r;
    assign o_retired  = retired_r;

endmodule
